// File: rtl/fb_pkg.sv
// Shared types and constants for the 1-bpp framebuffer drawing blocks.
package fb_pkg;

    localparam int H_PIXELS       = 640;
    localparam int V_PIXELS       = 480;
    localparam int FB_DATA_W      = 32;
    localparam int FB_ADDR_W      = 15;
    localparam int WORDS_PER_LINE = H_PIXELS / FB_DATA_W;
    localparam int FB_WORDS       = WORDS_PER_LINE * V_PIXELS;
    localparam int X_W            = 10;
    localparam int Y_W            = 9;

    typedef enum logic [1:0] {
        OP_SET    = 2'd0,
        OP_CLR    = 2'd1,
        OP_TOGGLE = 2'd2,
        OP_FILL   = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        WR   = 3'd3,
        FILL = 3'd4,
        ERR  = 3'd5
    } fb_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel (x,y) to framebuffer word/bit mapping for a 20-word line, plus range check.
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int H_PIX  = H_PIXELS,
    parameter int V_PIX  = V_PIXELS,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] word,
    output logic [4:0]        bit_idx,
    output logic              in_range
);

    logic [ADDR_W-1:0] y_ext;

    // y*20 as two shifts so no multiplier is inferred
    assign y_ext    = ADDR_W'(y);
    assign word     = (y_ext << 4) + (y_ext << 2) + ADDR_W'(x[9:5]);
    assign bit_idx  = x[4:0];
    assign in_range = (x < X_W'(H_PIX)) && (y < Y_W'(V_PIX));

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel command engine: read-modify-write for single pixels, full-frame fill.
//
// state | meaning
// IDLE  | ready for a command
// RD    | read address presented to the RAM
// WT    | RAM latency; read word captured at end of cycle
// WR    | modified word written back, op_done
// FILL  | one word per cycle, counter 0..last
// ERR   | out-of-range pixel: err and op_done for one cycle
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int H_PIXELS = fb_pkg::H_PIXELS,
    parameter int V_PIXELS = fb_pkg::V_PIXELS,
    parameter int DATA_W   = FB_DATA_W,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic              cmd_fill,
    output logic [ADDR_W-1:0] fb_rdaddress,
    input  logic [DATA_W-1:0] fb_q,
    output logic [ADDR_W-1:0] fb_wraddress,
    output logic [DATA_W-1:0] fb_data,
    output logic              fb_wren,
    output logic              busy,
    output logic              op_done,
    output logic              err
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'((H_PIXELS / DATA_W) * V_PIXELS - 1);

    fb_state_e         state, state_nxt;
    cmd_op_e           op_in, op_q;
    logic [ADDR_W-1:0] calc_word, word_q, fill_cnt;
    logic [4:0]        calc_bit;
    logic              calc_in_range;
    logic [BIT_W-1:0]  bit_q;
    logic              fill_q;
    logic [DATA_W-1:0] rd_q, bit_mask, rmw_data;
    logic              accept;

    fb_addr_calc #(
        .H_PIX  (H_PIXELS),
        .V_PIX  (V_PIXELS),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x        (cmd_x),
        .y        (cmd_y),
        .word     (calc_word),
        .bit_idx  (calc_bit),
        .in_range (calc_in_range)
    );

    assign op_in     = cmd_op_e'(cmd_op);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_SET;
            word_q       <= '0;
            bit_q        <= '0;
            fill_q       <= 1'b0;
            rd_q         <= '0;
            fill_cnt     <= '0;
            fb_rdaddress <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= op_in;
                word_q   <= calc_word;
                bit_q    <= BIT_W'(calc_bit);
                fill_q   <= cmd_fill;
                fill_cnt <= '0;
                // the read port only moves for a pixel op that will actually read
                if (op_in != OP_FILL && calc_in_range) begin
                    fb_rdaddress <= calc_word;
                end
            end
            if (state == WT) begin
                rd_q <= fb_q;
            end
            if (state == FILL) begin
                fill_cnt <= (fill_cnt == LAST_WORD) ? '0 : fill_cnt + 1'b1;
            end
        end
    end

    assign bit_mask = DATA_W'(1) << bit_q;

    always_comb begin
        rmw_data = rd_q;
        case (op_q)
            OP_SET:    rmw_data = rd_q | bit_mask;
            OP_CLR:    rmw_data = rd_q & ~bit_mask;
            OP_TOGGLE: rmw_data = rd_q ^ bit_mask;
            default:   rmw_data = rd_q;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        fb_wren      = 1'b0;
        fb_wraddress = '0;
        fb_data      = '0;
        op_done      = 1'b0;
        err          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_in == OP_FILL) begin
                        state_nxt = FILL;
                    end else if (!calc_in_range) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: state_nxt = WT;
            WT: state_nxt = WR;
            WR: begin
                fb_wren      = 1'b1;
                fb_wraddress = word_q;
                fb_data      = rmw_data;
                op_done      = 1'b1;
                state_nxt    = IDLE;
            end
            FILL: begin
                fb_wren      = 1'b1;
                fb_wraddress = fill_cnt;
                fb_data      = {DATA_W{fill_q}};
                if (fill_cnt == LAST_WORD) begin
                    op_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                err       = 1'b1;
                op_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Drawing engine upstream of the VGA display stage. Turns pixel commands into writes to the shared 1-bpp framebuffer RAM.
- The framebuffer holds 640x480 pixels in 9600 32-bit words, row-major, 20 words per line.
- Single pixels use read-modify-write on the RAM's second port. A fill command writes every word of the frame.
- The display block scans the same RAM, so software draws pixels instead of poking whole words over Avalon.

Parameters:
H_PIXELS, 640, visible columns
V_PIXELS, 480, visible rows
DATA_W, 32, framebuffer word width (pixels per word)
ADDR_W, 15, framebuffer word address width
WORDS_PER_LINE, H_PIXELS/DATA_W = 20, derived; not overridable

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept a command (IDLE only)
cmd_op  in  2  0=SET, 1=CLR, 2=TOGGLE, 3=FILL
cmd_x  in  10  pixel column
cmd_y  in  9  pixel row
cmd_fill  in  1  FILL value: 1 = all pixels on, 0 = all off
fb_rdaddress  out  ADDR_W  framebuffer read word address
fb_q  in  DATA_W  read data, valid one clk after fb_rdaddress is sampled
fb_wraddress  out  ADDR_W  framebuffer write word address
fb_data  out  DATA_W  write data
fb_wren  out  1  write strobe, one word per cycle
busy  out  1  state != IDLE
op_done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse when a command is out of range

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - state=IDLE; cmd_ready=1 (after reset deasserts); busy=0.
  - fb_wren=0, op_done=0, err=0.
  - fb_rdaddress=0, fb_wraddress=0, fb_data=0; fill counter=0.
- Handshake:
  - A command is accepted on a clk edge where cmd_valid & cmd_ready.
  - cmd_ready = (state==IDLE).
  - Operands are registered at acceptance; inputs may change afterwards.
- Address math, no multiplier:
  - word = (y<<4) + (y<<2) + x[9:5].
  - bit = x[4:0]; word bit n is the nth pixel from the word's left edge.
  - Maximum word = 9599.
- Range check: x >= H_PIXELS or y >= V_PIXELS (does not apply to FILL).
  - Accept, go to ERR for one cycle: err=1, op_done=1, no RAM access, then IDLE.
- Pixel ops (SET/CLR/TOGGLE), accepted at edge T:
  - RD (cycle T+1): fb_rdaddress=word.
  - WT (T+2): wait for RAM latency; capture fb_q at end of cycle.
  - WR (T+3): fb_wren=1, fb_wraddress=word, fb_data = captured word with bit forced to 1 / 0 / inverted. op_done=1.
  - IDLE at T+4. Throughput is one pixel per 4 cycles.
  - No pipelining, so back-to-back pixel ops in the same word never see stale data.
- FILL:
  - State FILL, counter 0..9599.
  - Each cycle: fb_wren=1, fb_wraddress=counter, fb_data = {32{cmd_fill}}.
  - The cycle writing 9599 asserts op_done; IDLE next cycle. Total 9600 write cycles.
  - fb_rdaddress is held during FILL.
- fb_wren is 0 in every state except WR and FILL.
- Reset mid-operation: next edge forces IDLE and fb_wren=0.
  - A partial fill is abandoned; framebuffer contents are not restored.
  - A pending read-modify-write is discarded.
- cmd_valid while busy: ignored (not accepted); the upstream master holds it.
- Illegal states decode to IDLE.

Decomposition:
- Package fb_pkg:
  - cmd_op enum (OP_SET, OP_CLR, OP_TOGGLE, OP_FILL).
  - FB_WORDS=9600, H_PIXELS, V_PIXELS, FB_ADDR_W, FB_DATA_W.
  - FSM state enum (IDLE, RD, WT, WR, FILL, ERR).
- Sub-module fb_addr_calc: combinational (x,y) -> word, bit, in_range. Reused later by line/rectangle drawers.

Test Plan:
- Reset, then SET x=0 y=0 on a zero-initialised RAM model -> fb_rdaddress=0 at T+1; fb_wren=1, fb_wraddress=0, fb_data=32'h00000001 at T+3; op_done at T+3; cmd_ready back at T+4.
- SET x=639 y=479, then TOGGLE same pixel -> first write word 9599 = 32'h80000000; second write word 9599 = 32'h00000000.
- RAM word 45 preloaded 32'hFFFFFFFF; CLR x=165 y=2 (word 2*20+5=45, bit 5) -> write 32'hFFFFFFDF to address 45.
- FILL cmd_fill=1 -> 9600 consecutive fb_wren cycles, addresses 0..9599, data 32'hFFFFFFFF; op_done coincides with address 9599; busy deasserts next cycle; cmd_valid held during fill is not accepted until IDLE.
- SET x=640 y=0, then SET x=0 y=480 -> each gives err=1 and op_done=1 for one cycle, no fb_wren, cmd_ready again 2 cycles after acceptance.
- FILL, assert reset at write 1000 -> fb_wren=0 from the next edge; words 0..999 are written and 1000+ untouched; a subsequent SET behaves normally.
